io_feeder: RTL and testbench
============================

Name: io_feeder

Overview:
- Host-side driver for the processor's switch/LED handshake; it feeds operand bytes in and collects results out.
- Buffers operand bytes from an upstream byte stream (e.g. UART receiver) in a small FIFO.
- Presents each byte to the core on the 8-bit switch bus, qualified by bflag, and waits for the core's acknowledge.
- Captures changes on the core's 8-bit LED/result bus as a one-cycle result stream.

Parameters:
- DEPTH, 4, operand FIFO entries; power of two, at least 2.
- GAP, 2, cycles bflag is held low between consecutive operands; at least 1.
- n, 8, data width of the switch and LED buses.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- in_data  input  n  upstream operand byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  FIFO can accept; a write occurs when in_valid and in_ready are both high.
- sw_data  output  n  operand driven to the core's switch inputs [7:0].
- bflag  output  1  operand-present flag to the core's branch-flag input.
- cpu_ack  input  1  one-cycle pulse from the core: operand consumed.
- led  input  n  core result bus.
- res_data  output  n  captured result.
- res_valid  output  1  one-cycle pulse when res_data is new.
- level  output  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset values: in_ready=1, sw_data=0, bflag=0, res_data=0, res_valid=0, level=0. FIFO pointers are cleared, FSM goes to IDLE, gap counter=0.
- Reset mid-operation discards all buffered and presented data. The first led sample after reset establishes the baseline and produces no res_valid.
- FIFO:
  - Circular buffer with wrap-around pointers.
  - in_ready = (level != DEPTH).
  - Simultaneous push and pop when full is not possible, because in_ready=0 blocks the push.
  - Simultaneous push and pop at any other level leaves level unchanged.
- IDLE state:
  - bflag=0.
  - If level>0, pop the head into the sw_data register and go to PRESENT. bflag rises the next cycle, so latency is 1 cycle from FIFO-non-empty to bflag=1.
- PRESENT state:
  - bflag=1; sw_data is held stable.
  - On cpu_ack=1, drop bflag the next cycle, load the gap counter with GAP-1, and go to GAP.
  - sw_data keeps the consumed value until the next load.
- GAP state:
  - bflag=0.
  - Decrement the counter; when it reaches 0, go to IDLE.
  - Minimum spacing between the ack edge and the next bflag rise is GAP+1 cycles.
- cpu_ack outside PRESENT is ignored.
- cpu_ack held high for several cycles counts as exactly one ack; the next operand cannot be acked before its bflag rises.
- Result capture:
  - Register led every cycle into led_q.
  - If a baseline exists and led != led_q, then next cycle res_data=led_q(new) and res_valid=1 for exactly one cycle.
  - Equal consecutive values produce no pulse.
  - Capture is independent of the operand FSM.
- The level output is registered and updates the cycle after a push or pop.

Test Plan:
- Reset, then push 0x35 with the core idle → 1 cycle later sw_data=0x35 and bflag=1; bflag stays 1 for 20 cycles with no ack; level=0.
- Push 0x01, 0x02, 0x03 back to back; ack each in the cycle bflag rises → sw_data sequence 0x01, 0x02, 0x03; with GAP=2, bflag low exactly 3 cycles between each; order preserved.
- Push 6 bytes with DEPTH=4 and no ack → first byte presented, 4 buffered, in_ready=0; the sixth is accepted only after the first ack; level never exceeds 4.
- Pulse cpu_ack while in IDLE or GAP, and hold it for 3 cycles in PRESENT → stray pulses ignored; the held pulse consumes one operand only.
- Drive led 0x00 → 0x7F → 0x7F → 0x80 → res_valid pulses twice, with res_data 0x7F then 0x80; no pulse for the repeated 0x7F or for the post-reset baseline.
- Assert reset while in PRESENT with 3 bytes queued → next cycle bflag=0, level=0, in_ready=1; a new push 0xAA after reset is the next value presented.

Source files
------------

// File: rtl/io_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : io_feeder
//  Description : Host-side feeder for the core's switch/LED handshake.
//                Buffers upstream operand bytes in a small FIFO, presents
//                them one at a time on the switch bus qualified by bflag,
//                waits for the core's acknowledge, and turns changes on the
//                core's LED bus into a one-cycle result stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module io_feeder #(
   parameter int DEPTH = 4,   // operand FIFO entries, power of two, >= 2
   parameter int GAP   = 2,   // bflag-low cycles between operands, >= 1
   parameter int N     = 8    // switch / LED bus width
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N-1:0]            in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [N-1:0]            sw_data,
   output logic                    bflag,
   input  logic                    cpu_ack,
   input  logic [N-1:0]            led,
   output logic [N-1:0]            res_data,
   output logic                    res_valid,
   output logic [$clog2(DEPTH):0]  level
);

   localparam int c_aw = $clog2(DEPTH);
   localparam int c_gw = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [c_aw:0]   c_full     = (c_aw + 1)'(DEPTH);
   localparam logic [c_gw-1:0] c_gap_load = c_gw'(GAP - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESENT = 2'd1,
      ST_GAP     = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [N-1:0]      mem_q [DEPTH];
   logic [c_aw-1:0]   wr_ptr_q, wr_ptr_d;
   logic [c_aw-1:0]   rd_ptr_q, rd_ptr_d;
   logic [c_aw:0]     level_q, level_d;
   logic [N-1:0]      sw_data_q, sw_data_d;
   logic              bflag_q, bflag_d;
   logic [c_gw-1:0]   gap_cnt_q, gap_cnt_d;
   logic [N-1:0]      led_q;
   logic              base_q;
   logic [N-1:0]      res_data_q, res_data_d;
   logic              res_valid_q, res_valid_d;
   logic              w_push;
   logic              w_pop;

   // A full FIFO refuses input, so push and pop never collide at DEPTH
   assign in_ready = (level_q != c_full);
   assign w_push   = in_valid && in_ready;
   // The head is taken only when idle and something is buffered
   assign w_pop    = (state_q == ST_IDLE) && (level_q != '0);

   assign sw_data   = sw_data_q;
   assign bflag     = bflag_q;
   assign level     = level_q;
   assign res_data  = res_data_q;
   assign res_valid = res_valid_q;

   // Operand handshake sequencing and FIFO pointer / occupancy update
   always_comb begin
      state_d   = state_q;
      sw_data_d = sw_data_q;
      bflag_d   = bflag_q;
      gap_cnt_d = gap_cnt_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      level_d   = level_q;

      case (state_q)
         ST_IDLE: begin
            bflag_d = 1'b0;
            if (w_pop) begin
               sw_data_d = mem_q[rd_ptr_q];
               bflag_d   = 1'b1;
               state_d   = ST_PRESENT;
            end
         end
         ST_PRESENT: begin
            // Only an ack seen here consumes the operand; a held ack is
            // swallowed by the following GAP/IDLE cycles
            if (cpu_ack) begin
               bflag_d   = 1'b0;
               gap_cnt_d = c_gap_load;
               state_d   = ST_GAP;
            end
         end
         ST_GAP: begin
            bflag_d = 1'b0;
            if (gap_cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q - 1'b1;
            end
         end
         default: begin
            bflag_d = 1'b0;
            state_d = ST_IDLE;
         end
      endcase

      if (w_push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (w_push && !w_pop) begin
         level_d = level_q + 1'b1;
      end else if (!w_push && w_pop) begin
         level_d = level_q - 1'b1;
      end
   end

   // A result is emitted only once a post-reset baseline sample exists
   always_comb begin
      res_valid_d = base_q && (led != led_q);
      res_data_d  = res_valid_d ? led : res_data_q;
   end

   // State, FIFO bookkeeping and result capture registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         sw_data_q   <= '0;
         bflag_q     <= 1'b0;
         gap_cnt_q   <= '0;
         led_q       <= '0;
         base_q      <= 1'b0;
         res_data_q  <= '0;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         sw_data_q   <= sw_data_d;
         bflag_q     <= bflag_d;
         gap_cnt_q   <= gap_cnt_d;
         led_q       <= led;
         base_q      <= 1'b1;
         res_data_q  <= res_data_d;
         res_valid_q <= res_valid_d;
      end
   end

   // Operand storage; no reset needed because occupancy gates every read
   always_ff @(posedge clk) begin
      if (w_push) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_io_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_io_feeder
//  Description : Self-checking bench for io_feeder with directed scenarios
//                and a randomized run against a queue-based reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_io_feeder;

   localparam int DEPTH = 4;
   localparam int GAP   = 2;
   localparam int N     = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [N-1:0] in_data = '0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [N-1:0] sw_data;
   logic         bflag;
   logic         cpu_ack = 1'b0;
   logic [N-1:0] led = '0;
   logic [N-1:0] res_data;
   logic         res_valid;
   logic [$clog2(DEPTH):0] level;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   io_feeder #(.DEPTH(DEPTH), .GAP(GAP), .N(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sw_data   (sw_data),
      .bflag     (bflag),
      .cpu_ack   (cpu_ack),
      .led       (led),
      .res_data  (res_data),
      .res_valid (res_valid),
      .level     (level)
   );

   // Reference: a byte queue for buffered operands, one "presented" slot,
   // and the earliest cycle at which the next operand may appear.
   logic [7:0] m_q[$];
   logic       m_pres = 1'b0;
   logic [7:0] m_val = '0;
   int         m_next_ok = 0;
   int         t_cyc = 0;
   logic       m_base = 1'b0;
   logic [7:0] m_led = '0;
   logic [7:0] m_rd = '0;
   logic       m_rv = 1'b0;
   logic       m_push, m_pop;

   always @(posedge clk) begin
      t_cyc = t_cyc + 1;
      if (reset) begin
         m_q.delete();
         m_pres = 1'b0; m_val = '0; m_next_ok = 0;
         m_base = 1'b0; m_led = '0; m_rd = '0; m_rv = 1'b0;
      end else begin
         m_push = in_valid && (m_q.size() < DEPTH);
         m_pop  = !m_pres && (t_cyc >= m_next_ok) && (m_q.size() > 0);
         if (m_pres && cpu_ack) begin
            m_pres    = 1'b0;
            m_next_ok = t_cyc + GAP + 1;
         end
         if (m_pop) begin
            m_val  = m_q.pop_front();
            m_pres = 1'b1;
         end
         if (m_push) m_q.push_back(in_data);
         m_rv = m_base && (led != m_led);
         if (m_rv) m_rd = led;
         m_led  = led;
         m_base = 1'b1;
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic reset_dut();
      reset = 1'b1; in_valid = 1'b0; cpu_ack = 1'b0;
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic settle();
      in_valid = 1'b0; cpu_ack = 1'b0;
      for (int i = 0; i < GAP + 3; i++) tick();
   endtask

   task automatic test_reset();
      led = 8'h00;
      reset_dut();
      n_checks++;
      if ({in_ready, sw_data, bflag, res_data, res_valid, level} !== {1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0})
         $display("FAIL reset_values: rdy=%b sw=%h bflag=%b rd=%h rv=%b lvl=%0d, want 1 00 0 00 0 0",
                  in_ready, sw_data, bflag, res_data, res_valid, level);
      else n_pass++;
      tick();
      n_checks++;
      if ({bflag, res_valid, level} !== {1'b0, 1'b0, 3'd0})
         $display("FAIL reset_idle: bflag=%b rv=%b lvl=%0d, want 0 0 0", bflag, res_valid, level);
      else n_pass++;
   endtask

   task automatic test_single();
      int hi_cnt;
      in_data = 8'h35; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n_checks++;
      if ({bflag, level} !== {1'b0, 3'd1})
         $display("FAIL single_buffered: bflag=%b lvl=%0d, want 0 1", bflag, level);
      else n_pass++;
      tick();
      n_checks++;
      if ({bflag, sw_data, level} !== {1'b1, 8'h35, 3'd0})
         $display("FAIL single_present: bflag=%b sw=%h lvl=%0d, want 1 35 0", bflag, sw_data, level);
      else n_pass++;
      hi_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bflag === 1'b1 && sw_data === 8'h35) hi_cnt++;
      end
      n_checks++;
      if (hi_cnt != 20)
         $display("FAIL single_hold: stable cycles=%0d, want 20", hi_cnt);
      else n_pass++;
      cpu_ack = 1'b1;
      tick();
      cpu_ack = 1'b0;
      n_checks++;
      if ({bflag, sw_data} !== {1'b0, 8'h35})
         $display("FAIL single_ack_drop: bflag=%b sw=%h, want 0 35", bflag, sw_data);
      else n_pass++;
      settle();
   endtask

   task automatic test_back_to_back();
      logic [7:0] seen[$];
      int  low_run;
      bit  any_seen;
      low_run = 0; any_seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         in_valid = (i < 3);
         in_data  = 8'(i + 1);
         cpu_ack  = bflag;
         if (bflag === 1'b1) begin
            if (any_seen) begin
               n_checks++;
               if (low_run != GAP + 1)
                  $display("FAIL b2b_gap: bflag low %0d cycles, want %0d", low_run, GAP + 1);
               else n_pass++;
            end
            seen.push_back(sw_data);
            any_seen = 1'b1;
            low_run  = 0;
         end else if (any_seen) begin
            low_run++;
         end
         tick();
      end
      in_valid = 1'b0; cpu_ack = 1'b0;
      n_checks++;
      if (seen.size() != 3 || seen[0] !== 8'h01 || seen[1] !== 8'h02 || seen[2] !== 8'h03)
         $display("FAIL b2b_order: got %0d values first=%h, want 01 02 03",
                  seen.size(), (seen.size() > 0) ? seen[0] : 8'hxx);
      else n_pass++;
   endtask

   task automatic test_full();
      logic [7:0] bytes[6];
      logic [7:0] seen[$];
      int  acc, max_lvl, idx, bad_ord;
      bit  take, first_ack;
      for (int k = 0; k < 6; k++) bytes[k] = 8'($urandom);
      acc = 0; max_lvl = 0; first_ack = 1'b1;
      for (int i = 0; i < 12; i++) begin
         idx      = (acc < 6) ? acc : 0;
         take     = (acc < 6) && in_ready;
         in_valid = (acc < 6);
         in_data  = bytes[idx];
         tick();
         if (take) acc++;
         if (int'(level) > max_lvl) max_lvl = int'(level);
      end
      n_checks++;
      if (acc != 5 || {level, in_ready, bflag, sw_data} !== {3'd4, 1'b0, 1'b1, bytes[0]})
         $display("FAIL full_hold: acc=%0d lvl=%0d rdy=%b bflag=%b sw=%h, want 5 4 0 1 %h",
                  acc, level, in_ready, bflag, sw_data, bytes[0]);
      else n_pass++;
      for (int i = 0; i < 60; i++) begin
         idx      = (acc < 6) ? acc : 0;
         take     = (acc < 6) && in_ready;
         in_valid = (acc < 6);
         in_data  = bytes[idx];
         cpu_ack  = bflag;
         if (bflag === 1'b1) begin
            if (first_ack) begin
               n_checks++;
               if (acc != 5)
                  $display("FAIL full_stall: accepted %0d before first ack, want 5", acc);
               else n_pass++;
               first_ack = 1'b0;
            end
            seen.push_back(sw_data);
         end
         tick();
         if (take) acc++;
         if (int'(level) > max_lvl) max_lvl = int'(level);
      end
      in_valid = 1'b0; cpu_ack = 1'b0;
      bad_ord = (seen.size() != 6) ? 1 : 0;
      for (int k = 0; k < 6 && k < seen.size(); k++)
         if (seen[k] !== bytes[k]) bad_ord++;
      n_checks++;
      if (acc != 6 || bad_ord != 0)
         $display("FAIL full_order: accepted=%0d presented=%0d bad=%0d, want 6 6 0",
                  acc, seen.size(), bad_ord);
      else n_pass++;
      n_checks++;
      if (max_lvl != DEPTH)
         $display("FAIL full_maxlevel: peak level=%0d, want %0d", max_lvl, DEPTH);
      else n_pass++;
   endtask

   task automatic test_stray_ack();
      cpu_ack = 1'b1;
      tick(); tick();
      cpu_ack = 1'b0;
      n_checks++;
      if ({bflag, level} !== {1'b0, 3'd0})
         $display("FAIL stray_idle: bflag=%b lvl=%0d, want 0 0", bflag, level);
      else n_pass++;
      in_valid = 1'b1; in_data = 8'h11; tick();
      in_data = 8'h22; tick();
      in_valid = 1'b0;
      n_checks++;
      if ({bflag, sw_data, level} !== {1'b1, 8'h11, 3'd1})
         $display("FAIL stray_first: bflag=%b sw=%h lvl=%0d, want 1 11 1", bflag, sw_data, level);
      else n_pass++;
      cpu_ack = 1'b1;
      tick(); tick(); tick();
      cpu_ack = 1'b0;
      n_checks++;
      if ({bflag, level} !== {1'b0, 3'd1})
         $display("FAIL stray_held: bflag=%b lvl=%0d, want 0 1", bflag, level);
      else n_pass++;
      tick();
      n_checks++;
      if ({bflag, sw_data, level} !== {1'b1, 8'h22, 3'd0})
         $display("FAIL stray_next: bflag=%b sw=%h lvl=%0d, want 1 22 0", bflag, sw_data, level);
      else n_pass++;
      cpu_ack = 1'b1; tick();
      in_valid = 1'b1; in_data = 8'h33; tick();
      in_valid = 1'b0; tick(); tick();
      cpu_ack = 1'b0;
      n_checks++;
      if ({bflag, sw_data, level} !== {1'b1, 8'h33, 3'd0})
         $display("FAIL stray_gap_present: bflag=%b sw=%h lvl=%0d, want 1 33 0", bflag, sw_data, level);
      else n_pass++;
      tick();
      n_checks++;
      if ({bflag, sw_data} !== {1'b1, 8'h33})
         $display("FAIL stray_gap_hold: bflag=%b sw=%h, want 1 33", bflag, sw_data);
      else n_pass++;
      cpu_ack = 1'b1; tick();
      settle();
   endtask

   task automatic test_led();
      logic [7:0] seq[7];
      logic [7:0] pulses[$];
      int rv_cnt;
      seq = '{8'h00, 8'h7F, 8'h7F, 8'h80, 8'h80, 8'h80, 8'h80};
      led = 8'h00;
      reset_dut();
      for (int i = 0; i < 7; i++) begin
         led = seq[i];
         tick();
         if (res_valid === 1'b1) pulses.push_back(res_data);
      end
      n_checks++;
      if (pulses.size() != 2 || pulses[0] !== 8'h7F || pulses[1] !== 8'h80)
         $display("FAIL led_pulses: count=%0d first=%h, want 2 pulses 7f 80",
                  pulses.size(), (pulses.size() > 0) ? pulses[0] : 8'hxx);
      else n_pass++;
      n_checks++;
      if (res_data !== 8'h80)
         $display("FAIL led_hold: res_data=%h, want 80", res_data);
      else n_pass++;
      led = 8'hC3;
      reset_dut();
      rv_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (res_valid !== 1'b0) rv_cnt++;
      end
      n_checks++;
      if (rv_cnt != 0 || res_data !== 8'h00)
         $display("FAIL led_baseline: pulses=%0d res_data=%h, want 0 00", rv_cnt, res_data);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = 8'(8'h10 + i);
         tick();
      end
      in_valid = 1'b0;
      n_checks++;
      if ({bflag, sw_data, level} !== {1'b1, 8'h10, 3'd3})
         $display("FAIL midrst_pre: bflag=%b sw=%h lvl=%0d, want 1 10 3", bflag, sw_data, level);
      else n_pass++;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_checks++;
      if ({bflag, level, in_ready} !== {1'b0, 3'd0, 1'b1})
         $display("FAIL midrst_clear: bflag=%b lvl=%0d rdy=%b, want 0 0 1", bflag, level, in_ready);
      else n_pass++;
      in_valid = 1'b1; in_data = 8'hAA; tick();
      in_valid = 1'b0; tick();
      n_checks++;
      if ({bflag, sw_data} !== {1'b1, 8'hAA})
         $display("FAIL midrst_next: bflag=%b sw=%h, want 1 aa", bflag, sw_data);
      else n_pass++;
      cpu_ack = 1'b1; tick();
      settle();
   endtask

   task automatic test_random();
      reset_dut();
      for (int i = 0; i < 400; i++) begin
         in_valid = ($urandom_range(0, 2) != 0);
         in_data  = 8'($urandom);
         cpu_ack  = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 3) == 0) led = 8'($urandom_range(0, 3));
         reset    = ($urandom_range(0, 149) == 0);
         tick();
         n_checks++;
         if (bflag !== m_pres || sw_data !== m_val || int'(level) != m_q.size() ||
             in_ready !== (m_q.size() != DEPTH) || res_valid !== m_rv || res_data !== m_rd)
            $display("FAIL random_cycle%0d: bflag=%b sw=%h lvl=%0d rdy=%b rv=%b rd=%h, want %b %h %0d %b %b %h",
                     i, bflag, sw_data, level, in_ready, res_valid, res_data,
                     m_pres, m_val, m_q.size(), (m_q.size() != DEPTH), m_rv, m_rd);
         else n_pass++;
      end
      reset = 1'b0;
      settle();
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_single();
      test_back_to_back();
      test_full();
      test_stray_ack();
      test_led();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
